// File: rtl/core_pkg.sv
// Shared types and constants for the writeback stage of the RV32 core.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 64;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_READY     = 2'd2,
    ST_DRAIN     = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic              reg_wr;
    logic [REG_AW-1:0] rd;
    wb_sel_e           wb_sel;
    logic [2:0]        funct3;
    logic [1:0]        addr_lo;
    logic [XLEN-1:0]   result;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of MEM->WB handshake, data-memory response and writeback outputs.
interface wb_stage_if;
  import core_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_reg_wr;
  logic [REG_AW-1:0] in_rd;
  logic [1:0]        in_wb_sel;
  logic [XLEN-1:0]   in_alu_res;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_csr_rdata;
  logic [2:0]        in_funct3;
  logic              flush;
  logic              dmem_rvalid;
  logic [XLEN-1:0]   dmem_rdata;
  logic              reg_wr;
  logic [REG_AW-1:0] waddr;
  logic [XLEN-1:0]   wdata;
  logic              load_pend;
  logic [REG_AW-1:0] load_pend_rd;
  logic [CNT_W-1:0]  retired;

  // The writeback stage itself.
  modport slave (
    input  in_valid, in_reg_wr, in_rd, in_wb_sel, in_alu_res, in_pc,
           in_csr_rdata, in_funct3, flush, dmem_rvalid, dmem_rdata,
    output in_ready, reg_wr, waddr, wdata, load_pend, load_pend_rd, retired
  );

  // The surrounding pipeline / memory system.
  modport master (
    output in_valid, in_reg_wr, in_rd, in_wb_sel, in_alu_res, in_pc,
           in_csr_rdata, in_funct3, flush, dmem_rvalid, dmem_rdata,
    input  in_ready, reg_wr, waddr, wdata, load_pend, load_pend_rd, retired
  );

endinterface

// File: rtl/wb_stage_load_formatter.sv
// Extracts and extends the addressed byte/halfword of a raw load word.
module load_formatter
  import core_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the byte and halfword lanes selected by the low address bits.
  always_comb begin
    byte_sel = raw[7:0];
    case (addr_lo)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
  end

  // Extend the selected lane according to the load type; unknown codes pass the word.
  always_comb begin
    data = raw;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds the MEM/WB entry, waits for loads, drives the regfile write port.
module wb_stage
  import core_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  wb_stage_if.slave bus
);

  wb_state_e        state_q, state_d;
  wb_entry_t        entry_q, entry_d;
  logic [CNT_W-1:0] retired_q;
  logic [XLEN-1:0]  load_data;
  logic             in_ready;
  logic             accept;
  logic             write_en;

  load_formatter u_fmt (
    .funct3  (entry_q.funct3),
    .addr_lo (entry_q.addr_lo),
    .raw     (bus.dmem_rdata),
    .data    (load_data)
  );

  assign in_ready = (state_q == ST_EMPTY) || (state_q == ST_READY);
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Next state and next entry; a response in WAIT_LOAD beats a concurrent flush.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    case (state_q)
      ST_EMPTY, ST_READY: begin
        if (accept) begin
          entry_d.reg_wr  = bus.in_reg_wr;
          entry_d.rd      = bus.in_rd;
          entry_d.wb_sel  = wb_sel_e'(bus.in_wb_sel);
          entry_d.funct3  = bus.in_funct3;
          entry_d.addr_lo = bus.in_alu_res[1:0];
          case (wb_sel_e'(bus.in_wb_sel))
            WB_ALU:  entry_d.result = bus.in_alu_res;
            WB_PC4:  entry_d.result = bus.in_pc + 32'd4;
            WB_CSR:  entry_d.result = bus.in_csr_rdata;
            default: entry_d.result = '0;
          endcase
          state_d = (wb_sel_e'(bus.in_wb_sel) == WB_LOAD) ? ST_WAIT_LOAD : ST_READY;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_WAIT_LOAD: begin
        if (bus.dmem_rvalid) begin
          entry_d.result = (entry_q.wb_sel == WB_LOAD) ? load_data : entry_q.result;
          state_d        = ST_READY;
        end else if (bus.flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.dmem_rvalid) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Pipeline entry register.
  always_ff @(posedge clk) begin
    if (reset) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  // Retired counter: one per READY cycle, regardless of whether rd is written.
  always_ff @(posedge clk) begin
    if (reset)                     retired_q <= '0;
    else if (state_q == ST_READY)  retired_q <= retired_q + 1'b1;
  end

  assign write_en         = (state_q == ST_READY) && entry_q.reg_wr && (entry_q.rd != '0);
  assign bus.in_ready     = in_ready;
  assign bus.reg_wr       = write_en;
  assign bus.waddr        = write_en ? entry_q.rd : '0;
  assign bus.wdata        = write_en ? entry_q.result : '0;
  assign bus.load_pend    = (state_q == ST_WAIT_LOAD);
  assign bus.load_pend_rd = (state_q == ST_WAIT_LOAD) ? entry_q.rd : '0;
  assign bus.retired      = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for the writeback stage.
module tb_wb_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  wb_stage_if ifc ();

  wb_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic wr, input logic [REG_AW-1:0] rd,
                               input logic [1:0] sel, input logic [XLEN-1:0] alu,
                               input logic [XLEN-1:0] pc, input logic [XLEN-1:0] csr,
                               input logic [2:0] f3);
    ifc.in_valid     = valid;
    ifc.in_reg_wr    = wr;
    ifc.in_rd        = rd;
    ifc.in_wb_sel    = sel;
    ifc.in_alu_res   = alu;
    ifc.in_pc        = pc;
    ifc.in_csr_rdata = csr;
    ifc.in_funct3    = f3;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, 2'd0, '0, '0, '0, 3'd0);
  endtask

  task automatic expectWrite(input logic [REG_AW-1:0] addr, input logic [XLEN-1:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Advance one clock and let the scoreboard judge any write that appears.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (ifc.reg_wr === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("[TB] FAIL unexpected_write observed waddr=%0d wdata=0x%0h expected no write",
               ifc.waddr, ifc.wdata);
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        checkOutput("sb_waddr", 64'(ifc.waddr), 64'(w.addr));
        checkOutput("sb_wdata", 64'(ifc.wdata), 64'(w.data));
      end
    end
  endtask

  // Issue a load, hold it pending for 'waits' cycles, deliver the response in the last one.
  task automatic doLoad(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] addr,
                        input logic [2:0] f3, input logic [XLEN-1:0] rdata,
                        input logic [XLEN-1:0] exp_data, input int waits);
    applyStimulus(1'b1, 1'b1, rd, 2'd1, addr, '0, '0, f3);
    tick();
    idle();
    for (int i = 0; i < waits; i++) begin
      checkOutput("load_pend", 64'(ifc.load_pend), 64'd1);
      checkOutput("load_in_ready", 64'(ifc.in_ready), 64'd0);
      checkOutput("load_pend_rd", 64'(ifc.load_pend_rd), 64'(rd));
      if (i == waits - 1) begin
        ifc.dmem_rvalid = 1'b1;
        ifc.dmem_rdata  = rdata;
        expectWrite(rd, exp_data);
      end
      tick();
    end
    ifc.dmem_rvalid = 1'b0;
    checkOutput("load_commit_wr", 64'(ifc.reg_wr), 64'd1);
    checkOutput("load_pend_clear", 64'(ifc.load_pend), 64'd0);
    tick();
  endtask

  initial begin
    idle();
    ifc.flush       = 1'b0;
    ifc.dmem_rvalid = 1'b0;
    ifc.dmem_rdata  = '0;
    reset           = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    checkOutput("rst_reg_wr", 64'(ifc.reg_wr), 64'd0);
    checkOutput("rst_waddr", 64'(ifc.waddr), 64'd0);
    checkOutput("rst_wdata", 64'(ifc.wdata), 64'd0);
    checkOutput("rst_load_pend", 64'(ifc.load_pend), 64'd0);
    checkOutput("rst_load_pend_rd", 64'(ifc.load_pend_rd), 64'd0);
    checkOutput("rst_retired", ifc.retired, 64'd0);

    $display("[TB] single ALU op");
    applyStimulus(1'b1, 1'b1, 5'd5, 2'd0, 32'h1234_5678, 32'h100, 32'h0, 3'd0);
    expectWrite(5'd5, 32'h1234_5678);
    tick();
    checkOutput("alu_reg_wr", 64'(ifc.reg_wr), 64'd1);
    idle();
    tick();
    checkOutput("alu_wr_once", 64'(ifc.reg_wr), 64'd0);
    checkOutput("alu_retired", ifc.retired, 64'd1);

    $display("[TB] load formatting");
    doLoad(5'd6, 32'h0000_1002, F3_LB,  32'h0080_FF00, 32'hFFFF_FF80, 3);
    doLoad(5'd6, 32'h0000_1002, F3_LBU, 32'h0080_FF00, 32'h0000_0080, 1);
    doLoad(5'd6, 32'h0000_2002, F3_LH,  32'h8001_0000, 32'hFFFF_8001, 2);
    doLoad(5'd6, 32'h0000_2002, F3_LHU, 32'h8001_0000, 32'h0000_8001, 1);
    doLoad(5'd6, 32'h0000_2001, F3_LW,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    checkOutput("load_retired", ifc.retired, 64'd6);

    $display("[TB] flush during load");
    applyStimulus(1'b1, 1'b1, 5'd7, 2'd1, 32'h0000_3000, '0, '0, F3_LW);
    tick();
    idle();
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    checkOutput("drain_load_pend", 64'(ifc.load_pend), 64'd0);
    checkOutput("drain_in_ready", 64'(ifc.in_ready), 64'd0);
    tick();
    checkOutput("drain_hold", 64'(ifc.in_ready), 64'd0);
    ifc.dmem_rvalid = 1'b1;
    ifc.dmem_rdata  = 32'h5555_AAAA;
    tick();
    ifc.dmem_rvalid = 1'b0;
    checkOutput("drain_done_ready", 64'(ifc.in_ready), 64'd1);
    checkOutput("drain_retired", ifc.retired, 64'd6);

    $display("[TB] flush and response together");
    applyStimulus(1'b1, 1'b1, 5'd8, 2'd1, 32'h0000_3000, '0, '0, F3_LW);
    tick();
    idle();
    ifc.flush       = 1'b1;
    ifc.dmem_rvalid = 1'b1;
    ifc.dmem_rdata  = 32'h0BAD_F00D;
    expectWrite(5'd8, 32'h0BAD_F00D);
    tick();
    ifc.flush       = 1'b0;
    ifc.dmem_rvalid = 1'b0;
    checkOutput("race_commit", 64'(ifc.reg_wr), 64'd1);
    tick();

    $display("[TB] flush while READY");
    applyStimulus(1'b1, 1'b1, 5'd9, 2'd0, 32'h0000_0009, '0, '0, 3'd0);
    expectWrite(5'd9, 32'h0000_0009);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd10, 2'd0, 32'h0000_000A, '0, '0, 3'd0);
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    idle();
    checkOutput("flush_drop_wr", 64'(ifc.reg_wr), 64'd0);
    checkOutput("flush_retired", ifc.retired, 64'd8);

    $display("[TB] back-to-back ALU ops");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(i), 2'd0, 32'hA000_0000 + 32'(i), '0, '0, 3'd0);
      expectWrite(5'(i), 32'hA000_0000 + 32'(i));
      tick();
      checkOutput("b2b_reg_wr", 64'(ifc.reg_wr), 64'd1);
    end
    applyStimulus(1'b1, 1'b1, 5'd0, 2'd0, 32'hFFFF_FFFF, '0, '0, 3'd0);
    tick();
    checkOutput("x0_no_write", 64'(ifc.reg_wr), 64'd0);
    checkOutput("x0_wdata_zero", 64'(ifc.wdata), 64'd0);
    idle();
    tick();
    checkOutput("b2b_retired", ifc.retired, 64'd13);

    $display("[TB] PC+4 wrap and CSR select");
    applyStimulus(1'b1, 1'b1, 5'd1, 2'd2, 32'h1111_1111, 32'hFFFF_FFFC, 32'h2222_2222, 3'd0);
    expectWrite(5'd1, 32'h0000_0000);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd3, 2'd3, 32'h1111_1111, 32'h0000_0040, 32'hCAFE_0001, 3'd0);
    expectWrite(5'd3, 32'hCAFE_0001);
    tick();
    idle();
    tick();
    checkOutput("jal_csr_retired", ifc.retired, 64'd15);

    $display("[TB] reset during load");
    applyStimulus(1'b1, 1'b1, 5'd11, 2'd1, 32'h0000_4000, '0, '0, F3_LW);
    tick();
    idle();
    checkOutput("pre_rst_pend", 64'(ifc.load_pend), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_in_ready", 64'(ifc.in_ready), 64'd1);
    checkOutput("midrst_load_pend", 64'(ifc.load_pend), 64'd0);
    checkOutput("midrst_load_pend_rd", 64'(ifc.load_pend_rd), 64'd0);
    checkOutput("midrst_reg_wr", 64'(ifc.reg_wr), 64'd0);
    checkOutput("midrst_retired", ifc.retired, 64'd0);
    ifc.dmem_rvalid = 1'b1;
    ifc.dmem_rdata  = 32'h7777_7777;
    tick();
    ifc.dmem_rvalid = 1'b0;
    checkOutput("stray_in_ready", 64'(ifc.in_ready), 64'd1);
    checkOutput("stray_reg_wr", 64'(ifc.reg_wr), 64'd0);
    tick();
    checkOutput("stray_retired", ifc.retired, 64'd0);

    checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the pipelined RV32 core; the sole driver of the integer register file write port (reg_wr/waddr/wdata).
- Holds the MEM/WB pipeline entry and waits for data-memory load responses.
- Formats load data and selects the final result (ALU, load, PC+4 or CSR).
- Publishes forwarding/hazard information and a retired-instruction count for the CSR unit.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width
CNT_W, 64, retired-instruction counter width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  stage can accept an instruction this cycle
in_reg_wr  input  1  instruction writes rd
in_rd  input  REG_AW  destination register
in_wb_sel  input  2  0=ALU, 1=load, 2=PC+4, 3=CSR
in_alu_res  input  XLEN  ALU result / load address
in_pc  input  XLEN  instruction PC
in_csr_rdata  input  XLEN  CSR old value
in_funct3  input  3  load type
flush  input  1  kill the uncommitted in-flight load and drop the in_valid presented this cycle
dmem_rvalid  input  1  load response valid
dmem_rdata  input  XLEN  raw load word
reg_wr  output  1  register file write enable
waddr  output  REG_AW  register file write address
wdata  output  XLEN  register file write data
load_pend  output  1  a load is awaiting its response
load_pend_rd  output  REG_AW  rd of the pending load
retired  output  CNT_W  count of retired instructions

Behaviour:
- States:
  - EMPTY: no entry held.
  - WAIT_LOAD: load awaiting dmem_rvalid.
  - READY: final data held; write presented this cycle.
  - DRAIN: flushed load; its response must be discarded.
- Reset:
  - state=EMPTY; entry fields 0; retired=0.
  - All outputs 0, except in_ready=1.
- Acceptance and in_ready:
  - in_ready = (state==EMPTY || state==READY).
  - accept = in_valid && in_ready && !flush.
- Transitions on accept:
  - Capture all in_* fields.
  - in_wb_sel==1 -> WAIT_LOAD.
  - Otherwise -> READY, with result computed at capture: ALU res, PC+4 (mod 2^32) or CSR data.
- READY without accept -> EMPTY.
- WAIT_LOAD:
  - dmem_rvalid=1 -> latch formatted load data, go READY.
  - flush=1 (and dmem_rvalid=0) -> DRAIN.
  - flush and dmem_rvalid in the same cycle -> the response wins and the load commits (READY).
- DRAIN: dmem_rvalid=1 -> EMPTY, data discarded. The rd write is never issued.
- flush in READY or EMPTY: the held entry is committed and still writes. Only the in_valid presented that cycle is dropped.
- Write port:
  - reg_wr = (state==READY) && entry.reg_wr && entry.rd!=0; high exactly one cycle per instruction.
  - waddr/wdata are valid while reg_wr=1. They are 0 when reg_wr=0.
  - The register file writes on the falling edge of that cycle, so same-cycle decode reads see the value.
- Load formatting uses in_alu_res[1:0] as byte offset:
  - funct3 000 LB: sign-extend the byte at offset.
  - 001 LH: sign-extend the halfword at offset[1]*16.
  - 010 LW: whole word.
  - 100 LBU / 101 LHU: zero-extend.
  - Other codes: whole word.
  - Misalignment is trapped upstream and is not handled here.
- Load hazard outputs:
  - load_pend = state==WAIT_LOAD.
  - load_pend_rd = entry.rd when load_pend, else 0.
- retired:
  - Increments by 1 in every READY cycle, including rd=x0 and reg_wr=0 instructions.
  - Wraps at 2^CNT_W.
  - Drained loads do not count.
- Reset mid-load: returns to EMPTY. A later stray dmem_rvalid seen in EMPTY is ignored.

Decomposition:
- Package core_pkg holds:
  - wb_sel_e enum (WB_ALU, WB_LOAD, WB_PC4, WB_CSR).
  - load funct3 constants.
  - wb_state_e.
  - wb_entry_t struct (reg_wr, rd, wb_sel, funct3, addr_lo, result).
- One sub-module, load_formatter: combinational; funct3 + addr_lo + raw word in, formatted XLEN data out.

Test Plan:
1. ALU op rd=5, alu_res=0x12345678 -> reg_wr=1, waddr=5, wdata=0x12345678 in the cycle after accept; retired=1.
2. LB, addr_lo=2, dmem_rdata=0x0080FF00 delivered 3 cycles later:
   - load_pend=1 and in_ready=0 for 3 cycles.
   - then wdata=0xFFFFFF80; LBU on the same data gives 0x00000080.
3. LH, addr_lo=2, rdata=0x8001_0000 -> wdata=0xFFFF8001. LHU gives 0x00008001.
4. Load rd=7 in WAIT_LOAD, then flush:
   - DRAIN, no write to x7, retired unchanged.
   - next dmem_rvalid is discarded; in_ready returns to 1 the cycle after.
5. Back-to-back ALU ops rd=1..4 with in_valid held high:
   - four consecutive reg_wr pulses with waddr 1,2,3,4; retired=4.
   - an op with rd=0 gives reg_wr=0 while retired still increments.
6. JAL at pc=0xFFFFFFFC, wb_sel=PC4, rd=1 -> wdata=0x00000000. Reset asserted during WAIT_LOAD -> all outputs 0, in_ready=1.
